pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning tracked in-flight positions after ID (1=EX, 2=MEM, 3=WB); legal range 2..7.
REQ-002 SHALL have parameter LOAD_READY, default 3, meaning first position whose pipeline register holds load data; legal range 2..DEPTH.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, meaning ID-stage issue slots squashed per redirect; legal range 1..7.
REQ-004 SHALL have parameter FW, default clog2(DEPTH+1), meaning forward-select width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs1, id_rs2  in  5 each  ID source registers.
REQ-009 id_use_rs1, id_use_rs2  in  1 each  source actually read.
REQ-010 id_rd  in  5  ID destination.
REQ-011 id_regwrite  in  1  ID writes id_rd.
REQ-012 id_is_load  in  1  ID is a load.
REQ-013 ex_redirect  in  1  taken jump/branch resolved in EX this cycle.
REQ-014 stall  out  1  hold PC and IF/ID (combinational).
REQ-015 kill  out  1  insert bubble into ID/EX (combinational).
REQ-016 flush_ifid  out  1  clear IF/ID (combinational, equals ex_redirect).
REQ-017 ex_valid  out  1  registered; EX holds an issued instruction.
REQ-018 ex_fwd_a, ex_fwd_b  out  FW each  registered; 0 = register file, k = pipeline register at position k.
REQ-019 stall_count  out  32  registered count of stall cycles.

Function
REQ-020 Scoreboard SHALL hold DEPTH slots {valid, rd, wr, load}; slot p = instruction at position p.
REQ-021 Every cycle slots SHALL shift p to p+1; slot DEPTH retires.
REQ-022 Slot 1 SHALL load {1, id_rd, id_regwrite & (id_rd!=0), id_is_load} when issue = id_valid & !kill, else all-zero bubble.
REQ-023 Hazard match for source s: slot p valid & wr & rd==s & use flag set & s!=0; youngest (smallest p) match only SHALL count.
REQ-024 For match at p, target q=p+1: q>DEPTH -> select 0; q>=ready -> select q; else hazard; ready=LOAD_READY for loads, 2 otherwise.
REQ-025 stall SHALL be 1 when id_valid, no redirect or flush window, and either source has hazard.
REQ-026 kill SHALL equal stall | ex_redirect | (flush_cnt!=0).
REQ-027 On issue, ex_fwd_a/b SHALL register the selects of REQ-024; on bubble they SHALL register 0; ex_valid SHALL register issue.
REQ-028 On ex_redirect flush_cnt SHALL load FLUSH_CYCLES-1; otherwise decrement while nonzero; redirect during window reloads.
REQ-029 ex_redirect SHALL take priority over stall; stall SHALL be 0 that cycle.
REQ-030 stall_count SHALL increment each stall cycle and saturate at 32'hFFFF_FFFF.
REQ-031 Load-use stall SHALL self-release: inserted bubble advances producer until REQ-024 yields a select.

Reset
REQ-032 rst SHALL immediately clear all slots, flush_cnt, stall_count, ex_valid, ex_fwd_a, ex_fwd_b to 0.
REQ-033 rst mid-stall or mid-flush SHALL abandon it; first post-reset cycle SHALL see stall=0, kill=0 with id_valid=0.

Structure
REQ-034 Shared package SHALL hold REG_AW=5, FWD_RF=0, slot record type, LOAD_READY/DEPTH defaults.
REQ-035 Scoreboard shift register and match priority SHALL be one sub-module, hazard_scoreboard; flush counter, stall counter, output registers SHALL stay in top.

Verification
REQ-036 add x5 issued, next cycle add rs1=x5 -> stall=0, following cycle ex_fwd_a=2, ex_valid=1.
REQ-037 lw x6 then add rs2=x6 -> stall=1 one cycle, stall_count=1, ex_valid=0; next cycle issue, ex_fwd_b=3.
REQ-038 add x7, two unrelated instrs, then use x7 -> ex_fwd_a=0; producer rd=x0 -> selects always 0.
REQ-039 ex_redirect with id_valid held 1 -> flush_ifid=1, kill=1 for 2 cycles, ex_valid=0 for 2 cycles, then issue resumes.
REQ-040 ex_redirect coincident with load-use hazard -> stall=0, kill=1; rst asserted mid-flush -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// A slot describes one in-flight instruction at a position after ID.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW           = 5;
    localparam int FWD_RF           = 0;
    localparam int DEPTH_DEF        = 3;
    localparam int LOAD_READY_DEF   = 3;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int ALU_READY        = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight instruction scoreboard: shifts one position per cycle and
// resolves each ID source to a forward select or a hazard.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  slot_t             slot_in_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              use_rs1_i,
    input  logic              use_rs2_i,
    output logic              hazard_a_o,
    output logic              hazard_b_o,
    output logic [FW-1:0]     sel_a_o,
    output logic [FW-1:0]     sel_b_o
);

    slot_t             slot_q [1:DEPTH];
    logic [REG_AW-1:0] src;
    logic              use_src;
    int                ready;
    logic [FW-1:0]     sel [2];
    logic              haz [2];

    // NOTE: every slot is reset, not only the valid bit: this is control
    // state that must read as bubbles the instant reset is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 1; p <= DEPTH; p++) slot_q[p] <= SLOT_BUBBLE;
        end else begin
            // NOTE: non-blocking so each slot takes its neighbour's old value.
            slot_q[1] <= slot_in_i;
            for (int p = 2; p <= DEPTH; p++) slot_q[p] <= slot_q[p-1];
        end
    end

    // Oldest-to-youngest scan: the last (smallest p) match overrides.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        src     = '0;
        use_src = 1'b0;
        ready   = ALU_READY;
        for (int s = 0; s < 2; s++) begin
            src     = (s == 0) ? rs1_i : rs2_i;
            use_src = (s == 0) ? use_rs1_i : use_rs2_i;
            sel[s]  = FW'(FWD_RF);
            haz[s]  = 1'b0;
            for (int p = DEPTH; p >= 1; p--) begin
                if (slot_q[p].valid && slot_q[p].wr && slot_q[p].rd == src
                    && use_src && src != '0) begin
                    ready = slot_q[p].load ? LOAD_READY : ALU_READY;
                    if (p + 1 > DEPTH) begin
                        sel[s] = FW'(FWD_RF);
                        haz[s] = 1'b0;
                    end else if (p + 1 >= ready) begin
                        sel[s] = FW'(p + 1);
                        haz[s] = 1'b0;
                    end else begin
                        sel[s] = FW'(FWD_RF);
                        haz[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign hazard_a_o = haz[0];
    assign hazard_b_o = haz[1];
    assign sel_a_o    = sel[0];
    assign sel_b_o    = sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush window,
// registered EX forward selects and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int LOAD_READY   = LOAD_READY_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int FW           = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              kill,
    output logic              flush_ifid,
    output logic              ex_valid,
    output logic [FW-1:0]     ex_fwd_a,
    output logic [FW-1:0]     ex_fwd_b,
    output logic [31:0]       stall_count
);

    logic [2:0]    flush_cnt_q, flush_cnt_d;
    logic [31:0]   stall_count_q, stall_count_d;
    logic          ex_valid_q, ex_valid_d;
    logic [FW-1:0] ex_fwd_a_q, ex_fwd_a_d;
    logic [FW-1:0] ex_fwd_b_q, ex_fwd_b_d;
    logic          issue;
    logic          haz_a, haz_b;
    logic [FW-1:0] sel_a, sel_b;
    slot_t         slot_in;

    hazard_scoreboard #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .FW         (FW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .slot_in_i  (slot_in),
        .rs1_i      (id_rs1),
        .rs2_i      (id_rs2),
        .use_rs1_i  (id_use_rs1),
        .use_rs2_i  (id_use_rs2),
        .hazard_a_o (haz_a),
        .hazard_b_o (haz_b),
        .sel_a_o    (sel_a),
        .sel_b_o    (sel_b)
    );

    // A redirect or open flush window outranks any data hazard.
    assign flush_ifid = ex_redirect;
    assign stall      = id_valid && !ex_redirect && (flush_cnt_q == '0) && (haz_a || haz_b);
    assign kill       = stall || ex_redirect || (flush_cnt_q != '0);
    assign issue      = id_valid && !kill;

    always_comb begin
        slot_in = SLOT_BUBBLE;
        if (issue) begin
            slot_in = '{valid: 1'b1, rd: id_rd,
                        wr: id_regwrite && (id_rd != '0), load: id_is_load};
        end

        if (ex_redirect)             flush_cnt_d = 3'(FLUSH_CYCLES - 1);
        else if (flush_cnt_q != '0)  flush_cnt_d = flush_cnt_q - 3'd1;
        else                         flush_cnt_d = flush_cnt_q;

        stall_count_d = stall_count_q;
        if (stall && stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;

        ex_valid_d = issue;
        ex_fwd_a_d = issue ? sel_a : FW'(FWD_RF);
        ex_fwd_b_d = issue ? sel_b : FW'(FWD_RF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q   <= '0;
            stall_count_q <= '0;
            ex_valid_q    <= 1'b0;
            ex_fwd_a_q    <= '0;
            ex_fwd_b_q    <= '0;
        end else begin
            flush_cnt_q   <= flush_cnt_d;
            stall_count_q <= stall_count_d;
            ex_valid_q    <= ex_valid_d;
            ex_fwd_a_q    <= ex_fwd_a_d;
            ex_fwd_b_q    <= ex_fwd_b_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_fwd_a    = ex_fwd_a_q;
    assign ex_fwd_b    = ex_fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: the driver queues expected
// per-cycle outputs, an independent monitor compares them at the falling edge.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       redir;
    } stim_t;

    typedef struct packed {
        logic        st;
        logic        k;
        logic        fl;
        logic        ev;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, ex_redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall, kill, flush_ifid, ex_valid;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic [31:0] stall_count;

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  mon_exp, mon_act;
    string mon_name;
    int    n_checks = 0;
    int    n_pass   = 0;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .kill        (kill),
        .flush_ifid  (flush_ifid),
        .ex_valid    (ex_valid),
        .ex_fwd_a    (ex_fwd_a),
        .ex_fwd_b    (ex_fwd_b),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t nop();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s = '0;
        s.v = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.u1 = 1'b1; s.u2 = 1'b1;
        s.rd = rd; s.rw = 1'b1;
        return s;
    endfunction

    function automatic stim_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        stim_t s = '0;
        s.v = 1'b1; s.rs1 = rs1; s.u1 = 1'b1; s.rd = rd; s.rw = 1'b1; s.ld = 1'b1;
        return s;
    endfunction

    function automatic stim_t redir(input stim_t s);
        s.redir = 1'b1;
        return s;
    endfunction

    function automatic stim_t in_rst(input stim_t s);
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic obs_t ob(input logic st, input logic k, input logic fl, input logic ev,
                                input logic [1:0] fa, input logic [1:0] fb, input int sc);
        obs_t o;
        o.st = st; o.k = k; o.fl = fl; o.ev = ev; o.fa = fa; o.fb = fb; o.sc = 32'(sc);
        return o;
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got stall=%0d kill=%0d flush=%0d ev=%0d fa=%0d fb=%0d sc=%0d, want stall=%0d kill=%0d flush=%0d ev=%0d fa=%0d fb=%0d sc=%0d",
                     nm, act.st, act.k, act.fl, act.ev, act.fa, act.fb, act.sc,
                     exp.st, exp.k, exp.fl, exp.ev, exp.fa, exp.fb, exp.sc);
        end
    endtask

    task automatic step(input string nm, input stim_t s, input obs_t e);
        @(posedge clk);
        #1;
        rst         = s.rst;
        id_valid    = s.v;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_use_rs1  = s.u1;
        id_use_rs2  = s.u2;
        id_rd       = s.rd;
        id_regwrite = s.rw;
        id_is_load  = s.ld;
        ex_redirect = s.redir;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {stall, kill, flush_ifid, ex_valid, ex_fwd_a, ex_fwd_b, stall_count};
            check(mon_name, mon_act, mon_exp);
        end
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; id_rd = '0; id_regwrite = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;

        step("reset",            in_rst(nop()),             ob(0,0,0,0,0,0,0));
        step("post_reset",       nop(),                     ob(0,0,0,0,0,0,0));
        step("add_x5",           alu(5, 1, 2),              ob(0,0,0,0,0,0,0));
        step("use_x5_no_stall",  alu(8, 5, 0),              ob(0,0,0,1,0,0,0));
        step("fwd_a_mem",        nop(),                     ob(0,0,0,1,2,0,0));
        step("lw_x6",            lw(6, 1),                  ob(0,0,0,0,0,0,0));
        step("load_use_stall",   alu(9, 3, 6),              ob(1,1,0,1,0,0,0));
        step("load_use_bubble",  alu(9, 3, 6),              ob(0,0,0,0,0,0,1));
        step("fwd_b_wb",         alu(7, 1, 2),              ob(0,0,0,1,0,3,1));
        step("unrelated_1",      alu(10, 1, 2),             ob(0,0,0,1,0,0,1));
        step("unrelated_2",      alu(11, 1, 2),             ob(0,0,0,1,0,0,1));
        step("use_x7_regfile",   alu(12, 7, 7),             ob(0,0,0,1,0,0,1));
        step("producer_x0",      alu(0, 1, 2),              ob(0,0,0,1,0,0,1));
        step("use_x0",           alu(13, 0, 0),             ob(0,0,0,1,0,0,1));
        step("lw_x14",           lw(14, 1),                 ob(0,0,0,1,0,0,1));
        step("add_x14",          alu(14, 2, 3),             ob(0,0,0,1,0,0,1));
        step("youngest_wins",    alu(15, 14, 0),            ob(0,0,0,1,0,0,1));
        step("redirect",         redir(alu(16, 1, 2)),      ob(0,1,1,1,2,0,1));
        step("flush_window",     alu(16, 1, 2),             ob(0,1,0,0,0,0,1));
        step("issue_resumes",    alu(16, 1, 2),             ob(0,0,0,0,0,0,1));
        step("resumed_valid",    nop(),                     ob(0,0,0,1,0,0,1));
        step("lw_x17",           lw(17, 1),                 ob(0,0,0,0,0,0,1));
        step("redirect_vs_load", redir(alu(18, 17, 0)),     ob(0,1,1,1,0,0,1));
        step("redirect_reload",  redir(alu(18, 17, 0)),     ob(0,1,1,0,0,0,1));
        step("reloaded_window",  alu(18, 17, 0),            ob(0,1,0,0,0,0,1));
        step("window_closed",    alu(18, 17, 0),            ob(0,0,0,0,0,0,1));
        step("lw_x19",           lw(19, 1),                 ob(0,0,0,1,0,0,1));
        step("stall_again",      alu(20, 19, 0),            ob(1,1,0,1,0,0,1));
        step("flush_open",       redir(alu(20, 19, 0)),     ob(0,1,1,0,0,0,2));
        step("rst_mid_flush",    in_rst(nop()),             ob(0,0,0,0,0,0,0));
        step("after_rst_flush",  nop(),                     ob(0,0,0,0,0,0,0));
        step("lw_x21",           lw(21, 1),                 ob(0,0,0,0,0,0,0));
        step("stall_pre_rst",    alu(22, 21, 0),            ob(1,1,0,1,0,0,0));
        step("rst_mid_stall",    in_rst(alu(22, 21, 0)),    ob(0,0,0,0,0,0,0));
        step("after_rst_stall",  nop(),                     ob(0,0,0,0,0,0,0));

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
